// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Data-memory bus between the core (master) and the responder (slave).
//   mem_addr      : byte address of the access
//   mem_data_in   : store bytes, lane 0 is the most significant byte
//   mem_write_en  : store request, sampled on each rising edge
//   mem_data_out  : load bytes, combinational from the responder
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic            mem_write_en;
    logic [0:3][7:0] mem_data_out;

    modport master (
        output mem_addr,
        output mem_data_in,
        output mem_write_en,
        input  mem_data_out
    );

    modport slave (
        input  mem_addr,
        input  mem_data_in,
        input  mem_write_en,
        output mem_data_out
    );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the core's data-memory port. Stores are posted into a
//   small circular write buffer and drained into a byte-addressed backing
//   array on cycles without a store request. Loads are forwarded byte by
//   byte from the youngest pending store covering each lane, so the core
//   never observes stale memory.
//
//   Ports:
//     clk        : the one clock, rising edge
//     rst_b      : asynchronous active-low reset
//     bus        : data-memory bus (slave side)
//     halted     : core halt indication
//     drained    : halted and the write buffer is empty
//     overflow   : sticky, a store was dropped because the buffer was full
//     occupancy  : number of valid write-buffer entries
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int MEM_BYTES = 65536,  // power of two, at least 4
    parameter int WB_DEPTH  = 4       // power of two, at least 2
) (
    input  logic                       clk,
    input  logic                       rst_b,
    data_mem_responder_if.slave        bus,
    input  logic                       halted,
    output logic                       drained,
    output logic                       overflow,
    output logic [$clog2(WB_DEPTH):0]  occupancy
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Backing array and write-buffer payload.
    logic [7:0]       mem     [MEM_BYTES];
    logic [IDX_W-1:0] wb_idx  [WB_DEPTH];
    logic [0:3][7:0]  wb_data [WB_DEPTH];

    // Buffer control.
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] index;
    logic             full;
    logic             empty;
    logic             push;
    logic             drop;
    logic             pop;

    // Address bits above the array size alias onto the same index.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_addr[31:IDX_W];

    assign index = bus.mem_addr[IDX_W-1:0];
    assign full  = (count == CNT_W'(WB_DEPTH));
    assign empty = (count == '0);

    // The array has a single write port, so a drain only happens on a cycle
    // with no store request; push and pop are therefore mutually exclusive.
    assign push = bus.mem_write_en && !full;
    assign drop = bus.mem_write_en &&  full;
    assign pop  = !bus.mem_write_en && !empty;

    assign occupancy = count;
    assign drained   = halted && empty;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, regardless of order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                tail  <= tail + PTR_W'(1);
                count <= count + CNT_W'(1);
            end else if (pop) begin
                head  <= head + PTR_W'(1);
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: payload storage carries no reset; validity comes solely from the
    // head/count window, so a reset discards pending stores by emptying it.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_idx[tail]  <= index;
            wb_data[tail] <= bus.mem_data_in;
        end
    end

    // Drain the oldest entry: all four lanes, wrapping past the array top.
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int k = 0; k < 4; k++) begin
                mem[wb_idx[head] + IDX_W'(k)] <= wb_data[head][k];
            end
        end
    end

    // Load path. Entries are scanned oldest to youngest so the last covering
    // hit wins, giving each lane the youngest pending byte for its address.
    // NOTE: every variable is assigned before use on each pass, so no latch
    // is inferred.
    always_comb begin
        logic [IDX_W-1:0] lane_addr;
        logic [IDX_W-1:0] diff;
        logic [PTR_W-1:0] slot;
        logic [7:0]       lane_byte;

        bus.mem_data_out = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr = index + IDX_W'(k);
            lane_byte = mem[lane_addr];
            for (int a = 0; a < WB_DEPTH; a++) begin
                slot = head + PTR_W'(a);
                // Offset of this lane inside the entry's 4-byte window,
                // modulo the array size so wrapped entries are covered too.
                diff = lane_addr - wb_idx[slot];
                if ((CNT_W'(a) < count) && (diff < IDX_W'(4))) begin
                    lane_byte = wb_data[slot][diff[1:0]];
                end
            end
            bus.mem_data_out[k] = lane_byte;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. A behavioural model keeps
//   committed array bytes and a queue of pending stores; expected load words
//   are queued when an address is driven and compared when the output is
//   sampled.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int MEM_BYTES = 65536;
    localparam int WB_DEPTH  = 4;
    localparam int MASK      = MEM_BYTES - 1;

    typedef struct {
        int              idx;
        logic [0:3][7:0] data;
    } wb_entry_t;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       halted;
    logic       drained;
    logic       overflow;
    logic [2:0] occupancy;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .MEM_BYTES (MEM_BYTES),
        .WB_DEPTH  (WB_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .bus       (bus),
        .halted    (halted),
        .drained   (drained),
        .overflow  (overflow),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Model state.
    logic [7:0]  m_mem [int];
    wb_entry_t   pend  [$];
    logic        m_ovf;
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] model_byte(input int a);
        logic [7:0] b;
        int         d;
        b = m_mem.exists(a) ? m_mem[a] : 8'h00;
        foreach (pend[i]) begin
            d = (a - pend[i].idx) & MASK;
            if (d < 4) b = pend[i].data[d];
        end
        return b;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [0:3][7:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k] = model_byte((int'(addr) + k) & MASK);
        end
        return w;
    endfunction

    // Apply one rising edge to the model, using the inputs held at the edge.
    task automatic model_edge();
        wb_entry_t e;
        if (!rst_b) return;
        if (bus.mem_write_en) begin
            if (pend.size() < WB_DEPTH) begin
                e.idx  = int'(bus.mem_addr) & MASK;
                e.data = bus.mem_data_in;
                pend.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (pend.size() > 0) begin
            e = pend.pop_front();
            for (int k = 0; k < 4; k++) m_mem[(e.idx + k) & MASK] = e.data[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_addr     = addr;
        bus.mem_data_in  = data;
        bus.mem_write_en = 1'b1;
        tick();
        bus.mem_write_en = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.mem_write_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr);
        bus.mem_addr = addr;
        exp_q.push_back(model_word(addr));
        #1;
        check(tag, bus.mem_data_out, exp_q.pop_front());
    endtask

    task automatic status_check(input string tag);
        check({tag, "_occ"},  32'(occupancy), 32'(pend.size()));
        check({tag, "_ovf"},  32'(overflow),  32'(m_ovf));
        check({tag, "_drn"},  32'(drained),   32'(halted && pend.size() == 0));
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic mid_reset(input string tag);
        #2;
        rst_b = 1'b0;
        pend.delete();
        m_ovf = 1'b0;
        #1;
        status_check(tag);
        check({tag, "_occ0"}, 32'(occupancy), 32'd0);
        #1;
        rst_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish by 200000");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] init_addrs [8];

        rst_b            = 1'b0;
        halted           = 1'b1;
        m_ovf            = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = 1'b0;

        // Reset state, with the core halted.
        #3;
        status_check("reset");
        check("reset_drained", 32'(drained), 32'd1);
        rst_b  = 1'b1;
        halted = 1'b0;
        tick();

        // Give the regions the later loads touch known contents. Stores are
        // interleaved with idle cycles so the buffer never fills here.
        init_addrs = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h208, 32'h20C,
                       32'h400, 32'h404};
        foreach (init_addrs[i]) begin
            store(init_addrs[i], $urandom);
            idle(1);
        end
        status_check("init");

        // Forwarding then drain.
        store(32'h100, 32'hDEAD_BEEF);
        load_check("fwd", 32'h100);
        check("fwd_const", bus.mem_data_out, 32'hDEAD_BEEF);
        check("fwd_occ1", 32'(occupancy), 32'd1);
        tick();
        check("drain_occ0", 32'(occupancy), 32'd0);
        load_check("drained_load", 32'h100);
        check("drained_const", bus.mem_data_out, 32'hDEAD_BEEF);
        load_check("alias_hi", 32'hABCD_0100);

        // Same-cycle store and load: output shows pre-store contents.
        bus.mem_data_in  = 32'h5566_7788;
        bus.mem_write_en = 1'b1;
        load_check("same_cycle", 32'h100);
        check("same_cycle_const", bus.mem_data_out, 32'hDEAD_BEEF);
        tick();
        bus.mem_write_en = 1'b0;
        load_check("next_cycle", 32'h100);
        check("next_cycle_const", bus.mem_data_out, 32'h5566_7788);
        idle(1);

        // Overlapping stores merge per lane.
        store(32'h200, 32'h1122_3344);
        store(32'h202, 32'hAABB_CCDD);
        load_check("merge_lo", 32'h200);
        check("merge_lo_const", bus.mem_data_out, 32'h1122_AABB);
        load_check("merge_hi", 32'h204);
        check("merge_hi_top", 32'(bus.mem_data_out[0:1]), 32'h0000_CCDD);
        idle(2);
        load_check("merge_lo_drn", 32'h200);
        load_check("merge_hi_drn", 32'h204);
        status_check("merge");

        // Overflow: the fifth consecutive store is dropped.
        store(32'h300, 32'h0102_0304);
        store(32'h304, 32'h0506_0708);
        store(32'h308, 32'h090A_0B0C);
        store(32'h30C, 32'h0D0E_0F10);
        store(32'h300, 32'h9999_9999);
        check("ovf_occ4", 32'(occupancy), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        load_check("ovf_fwd", 32'h300);
        check("ovf_fwd_const", bus.mem_data_out, 32'h0102_0304);
        idle(4);
        status_check("ovf_drained");
        check("ovf_sticky", 32'(overflow), 32'd1);
        load_check("ovf_arr", 32'h300);
        check("ovf_arr_const", bus.mem_data_out, 32'h0102_0304);
        load_check("ovf_arr_c", 32'h30C);

        // Wrap past the top of the array.
        store(32'(MEM_BYTES - 2), 32'h0102_0304);
        idle(1);
        load_check("wrap_top", 32'(MEM_BYTES - 2));
        check("wrap_top_const", bus.mem_data_out, 32'h0102_0304);
        load_check("wrap_zero", 32'h0);
        check("wrap_zero_top", 32'(bus.mem_data_out[0:1]), 32'h0000_0304);

        // Halt: drained rises exactly three cycles after three pushes.
        store(32'h500, 32'h1111_1111);
        store(32'h504, 32'h2222_2222);
        store(32'h508, 32'h3333_3333);
        halted = 1'b1;
        check("halt_busy", 32'(drained), 32'd0);
        n = 0;
        while (!drained && n < 10) begin
            tick();
            n++;
        end
        check("halt_latency", 32'(n), 32'd3);
        status_check("halt");
        halted = 1'b0;

        // Reset with two pending stores: they never reach the array.
        store(32'h400, 32'hF0F0_F0F0);
        store(32'h404, 32'h0F0F_0F0F);
        halted = 1'b1;
        check("rst_pend_busy", 32'(drained), 32'd0);
        mid_reset("rst_pend");
        idle(3);
        load_check("rst_lost_a", 32'h400);
        load_check("rst_lost_b", 32'h404);
        status_check("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the core's data-memory interface. It accepts the core's byte-lane loads and stores, posts stores into a small write buffer, and drains them into a byte-addressed backing array. Load data is forwarded byte by byte from pending stores, so a load never sees stale memory. The block sits between the core's data port and the backing memory, and reports when the buffer has drained after the core halts.

## Interface
- `MEM_BYTES`, 65536: backing array size in bytes. Must be a power of two.
- `WB_DEPTH`, 4: write-buffer entries. Must be a power of two, at least 2.
- `clk`  in  1: the one clock. All state changes on its rising edge.
- `rst_b`  in  1: reset, asynchronous, active-low.
- `mem_addr`  in  32: byte address of the access. Index = `mem_addr` mod `MEM_BYTES`.
- `mem_data_in`  in  4×8 (`[7:0] [0:3]`): store bytes. Lane k is written to address index+k.
- `mem_write_en`  in  1: store request, sampled on each rising edge.
- `halted`  in  1: core halt indication.
- `mem_data_out`  out  4×8 (`[7:0] [0:3]`): load bytes. Lane k is the byte at index+k.
- `drained`  out  1: `halted` is high and the buffer is empty.
- `overflow`  out  1: sticky flag; a store was dropped because the buffer was full.
- `occupancy`  out  $clog2(WB_DEPTH)+1: number of valid buffer entries.

## Operation
- Addressing: lane k maps to (index+k) mod `MEM_BYTES`. Accesses may be unaligned and wrap past the top of the array. Lane 0 is the most significant byte of a word.
- Buffer: circular FIFO. Each entry holds {index, 4 bytes}. It uses head and tail pointers plus a count; the pointers wrap at `WB_DEPTH`.
- Push: on an edge where `mem_write_en`=1 and count<`WB_DEPTH`, {index, `mem_data_in`} is enqueued.
- Drop: on an edge where `mem_write_en`=1 and count=`WB_DEPTH`, the store is discarded and `overflow` is set to 1. The buffer is unchanged.
- Drain: on an edge where `mem_write_en`=0 and count>0, the oldest entry is written to the array (all 4 lanes, with wrap) and popped. At most one drain per cycle. There is no drain on a store edge, because the array has a single write port.
- Load path, combinational: for each lane k, the address is (index+k) mod `MEM_BYTES`.
  - If any valid entry covers that address, the lane returns that byte from the youngest covering entry.
  - Otherwise the lane returns the array byte.
  - Different lanes may be sourced from different entries.
- Same-cycle store and load to the same address: `mem_data_out` shows contents from before the store. The store becomes visible from the next cycle.
- `drained` = `halted` && (count==0), combinational.
- `overflow` is cleared only by reset.

## Timing
- Reset, asynchronous on `rst_b` low: count=0, head=tail=0, `overflow`=0, hence `occupancy`=0 and `drained`=`halted`.
  - Backing array contents are not reset.
  - Reset mid-operation discards all pending stores at once. `mem_data_out` then reflects only the array.
- Store-to-load visibility: 1 cycle, through forwarding.
- Store-to-array latency: from 1 cycle after the push up to an unbounded time. Draining waits for a cycle with no store request.
- `occupancy` changes by at most ±1 per edge.
- Drain of N pending entries with no new stores takes N cycles. `drained` rises in the cycle after the last drain edge, if `halted` is high.
- `mem_data_out` has no registered latency. It settles within the cycle after `mem_addr` changes.

## Test plan
- Reset check: assert `rst_b`=0 mid-cycle → `occupancy`=0 and `overflow`=0 immediately. With `halted`=1, `drained`=1.
- Forwarding and drain:
  - Store 0xDE,0xAD,0xBE,0xEF at 0x100. Next cycle, load 0x100 with `mem_write_en`=0 → DE AD BE EF, `occupancy`=1.
  - One cycle later → `occupancy`=0; loading 0x100 still returns DE AD BE EF.
- Overlap merge:
  - Store 11 22 33 44 at 0x200, then AA BB CC DD at 0x202 on consecutive cycles.
  - Load 0x200 → 11 22 AA BB; load 0x204 → CC DD, then the array bytes at 0x206 and 0x207.
  - After 2 idle cycles the results are identical.
- Overflow (`WB_DEPTH`=4): issue 5 consecutive stores → `occupancy`=4 and `overflow`=1. The fifth store's data is never visible. `overflow` stays 1 after draining, until reset.
- Wrap: store 01 02 03 04 at `MEM_BYTES`-2. After draining, loading index `MEM_BYTES`-2 returns 01 02 03 04 and loading index 0 returns 03 04, then the array bytes at 2 and 3.
- Halt and reset:
  - Push 3 stores, then raise `halted` → `drained` rises exactly 3 cycles later.
  - Repeat with `rst_b` pulsed low while 2 entries are pending → `drained`=1 immediately; the pending bytes never reach the array.
